free_reg_list: RTL and testbench
================================

Name: free_reg_list

Overview:
- Circular FIFO of free physical register indices, directly upstream of the rename stage (RAT).
- Presents NUM_SLOTS = 2*INSTR_Q_WIDTH+2 candidate registers per cycle and pops exactly the slots the RAT marks consumed.
- Unconsumed slots inside the consumed span are recycled to the tail.
- Accepts registers freed by ROB commit, RET_WIDTH per cycle.

Parameters:
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS (128): physical register count; also FIFO depth.
- NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS (32): architectural GPRs; phys 0..NUM_ARCH_REGS (incl. NZCV) are mapped at reset.
- INSTR_Q_WIDTH, uop_pkg::INSTR_Q_WIDTH (2): rename width; NUM_SLOTS = 2*INSTR_Q_WIDTH+2 = 6.
- RET_WIDTH, 2: commit frees per cycle.
- PW (derived), $clog2(NUM_PHYS_REGS) = 7: register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_N_in  in  1  asynchronous active-low reset.
- frl_ready  in  NUM_SLOTS  per-slot consumed mask from RAT.
- free_register_data  out  NUM_SLOTS x PW  slot k = entry at head+k.
- frl_valid  out  1  high iff free_count >= NUM_SLOTS.
- commit_free_valid  in  RET_WIDTH  per-lane free request.
- commit_free_reg  in  RET_WIDTH x PW  register index being freed.
- free_count  out  $clog2(NUM_PHYS_REGS+1)  current occupancy.
- err_overflow  out  1  sticky; a push was dropped.
- err_underflow  out  1  sticky; consume attempted while !frl_valid.

Behaviour:
- Reset (async, immediate on rst_N_in low):
  - mem[i] = NUM_ARCH_REGS+1+i for i in 0..NUM_PHYS_REGS-NUM_ARCH_REGS-2.
  - head = 0; tail = count = NUM_PHYS_REGS-NUM_ARCH_REGS-1 (95).
  - Both error flags = 0.
  - Consequence: frl_valid = 1 and slots show 33..38 during reset.
- Outputs: free_register_data, frl_valid and free_count are combinational from registered head/count/mem only. There is no combinational path from any input.
- Consume (posedge, frl_ready != 0 and frl_valid = 1):
  - span = index of highest set bit + 1; pops = popcount(frl_ready).
  - head advances by span, modulo NUM_PHYS_REGS with explicit wrap compare; power-of-2 depth is not required.
  - Slots k < span with frl_ready[k] = 0 are recycled: pushed to the tail in ascending k order.
- Commit frees (posedge): each lane with commit_free_valid set pushes commit_free_reg, in lane order 0..RET_WIDTH-1.
  - Lanes are independent; sparse valid masks are allowed.
- Tail write order within one cycle: commit frees first, then recycled slots. Tail advances modulo NUM_PHYS_REGS.
- count_next = count - pops + committed_pushes. Recycled entries are count-neutral.
- Pushes made in a cycle appear on outputs only from the next cycle, even if count was below NUM_SLOTS.
- Underflow: frl_ready != 0 while frl_valid = 0.
  - No pop and no recycle; set err_underflow.
  - Commit frees that cycle are still accepted.
- Overflow: if count_next would exceed NUM_PHYS_REGS, drop the excess commit pushes (highest lanes first) and set err_overflow.
  - Recycles are never dropped.
- No duplicate-index checking. Indices 0..NUM_PHYS_REGS-1 are all legal.
- Error flags clear only on reset.
- frl_ready = 0: no pop. Commits still apply.

Test Plan:
- Reset:
  - Hold rst_N_in low, release.
  - Required: slots = 33,34,35,36,37,38; free_count = 95; frl_valid = 1; both errors 0.
- Full consume:
  - frl_ready = 6'b111111 for one edge.
  - Required next cycle: slots = 39..44; free_count = 89.
- Sparse consume with recycle:
  - From reset, frl_ready = 6'b010011.
  - Required: span 5, pops 3, head = 5; slots = 38,39,40,41,42,43; free_count = 92.
  - Required: mem[95] = 35, mem[96] = 36; tail = 97.
- Simultaneous commit + consume:
  - From reset, frl_ready = 6'b111111 with commit_free_valid = 2'b11, regs 5 and 7.
  - Required: free_count = 91; mem[95] = 5, mem[96] = 7.
- Drain, underflow, wrap:
  - Consume until free_count = 5; frl_valid must be 0.
  - Assert frl_ready = 6'b000001: err_underflow = 1, count stays 5.
  - Commit reg 9 in the same cycle: next cycle count = 6, frl_valid = 1.
  - Slot order shows the head wrapped past index 127 correctly.
- Async reset mid-operation:
  - After several pops/commits, pulse rst_N_in low between clock edges.
  - Required: outputs return to reset values immediately, with no clock edge.
  - Error flags clear.

Source files
------------

// File: rtl/free_reg_list.sv
`default_nettype none
// ============================================================================
//  Module   : free_reg_list
//  Purpose  : Circular FIFO of free physical register indices feeding rename.
//             Presents NUM_SLOTS candidate registers per cycle, pops exactly
//             the slots rename consumed, and pushes back unconsumed slots that
//             lie inside the consumed span. Accepts RET_WIDTH commit frees
//             per cycle.
//  Ports    : clk                 - clock, all state on posedge
//             rst_N_in            - asynchronous active-low reset
//             frl_ready           - per-slot consumed mask from rename
//             free_register_data  - slot k = FIFO entry at head+k
//             frl_valid           - free_count >= NUM_SLOTS
//             commit_free_valid   - per-lane commit free request
//             commit_free_reg     - per-lane freed register index
//             free_count          - current occupancy
//             err_overflow        - sticky, a commit push was dropped
//             err_underflow       - sticky, consume attempted while !frl_valid
//  Revision : 1.0 - initial release
// ============================================================================
module free_reg_list #(
  parameter int NUM_PHYS_REGS = 128,
  parameter int NUM_ARCH_REGS = 32,
  parameter int INSTR_Q_WIDTH = 2,
  parameter int RET_WIDTH     = 2,
  // Derived; not intended to be overridden.
  parameter int NUM_SLOTS     = 2*INSTR_Q_WIDTH+2,
  parameter int PW            = $clog2(NUM_PHYS_REGS),
  parameter int CW            = $clog2(NUM_PHYS_REGS+1)
) (
  input  logic                             clk,
  input  logic                             rst_N_in,
  input  logic [NUM_SLOTS-1:0]             frl_ready,
  output logic [NUM_SLOTS-1:0][PW-1:0]     free_register_data,
  output logic                             frl_valid,
  input  logic [RET_WIDTH-1:0]             commit_free_valid,
  input  logic [RET_WIDTH-1:0][PW-1:0]     commit_free_reg,
  output logic [CW-1:0]                    free_count,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  // Registers 0..NUM_ARCH_REGS (GPRs plus NZCV) are mapped at reset.
  localparam int c_RESET_CNT = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;
  localparam int c_SW        = $clog2(NUM_SLOTS+1);
  localparam int c_NPUSH     = RET_WIDTH + NUM_SLOTS;
  localparam int c_OW        = $clog2(c_NPUSH+1);

  logic [PW-1:0] r_mem [NUM_PHYS_REGS];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_err_overflow;
  logic          r_err_underflow;

  logic                 w_consume;
  logic                 w_underflow;
  logic                 w_overflow;
  logic [c_SW-1:0]      w_span;
  logic [c_SW-1:0]      w_pops;
  logic [CW-1:0]        w_cnt_run;
  logic [c_OW-1:0]      w_push_cnt;
  logic [c_NPUSH-1:0]   w_wr_en;
  logic [PW-1:0]        w_wr_ptr  [c_NPUSH];
  logic [PW-1:0]        w_wr_data [c_NPUSH];
  logic [PW-1:0]        w_head_next;
  logic [PW-1:0]        w_tail_next;

  // Explicit compare-and-subtract wrap so the depth need not be a power of 2.
  function automatic logic [PW-1:0] f_wrap(input logic [PW:0] s);
    if (s >= (PW+1)'(NUM_PHYS_REGS)) return PW'(s - (PW+1)'(NUM_PHYS_REGS));
    else                             return s[PW-1:0];
  endfunction

  // Outputs depend only on registered state.
  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      free_register_data[k] = r_mem[f_wrap({1'b0, r_head} + (PW+1)'(k))];
    end
  end

  assign frl_valid     = (r_count >= CW'(NUM_SLOTS));
  assign free_count    = r_count;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

  always_comb begin
    w_consume   = (|frl_ready) & frl_valid;
    w_underflow = (|frl_ready) & ~frl_valid;
    w_overflow  = 1'b0;
    w_span      = '0;
    w_pops      = '0;
    w_push_cnt  = '0;
    w_wr_en     = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (frl_ready[k]) begin
        w_span = c_SW'(k + 1);
        w_pops = w_pops + c_SW'(1);
      end
    end

    // Pops first, so commits can refill the room they make in the same cycle.
    w_cnt_run = r_count - (w_consume ? CW'(w_pops) : CW'(0));

    // Commit frees take the tail first, in lane order; once full, later
    // lanes are dropped, which drops the highest lanes first.
    for (int j = 0; j < RET_WIDTH; j++) begin
      w_wr_ptr[j]  = '0;
      w_wr_data[j] = commit_free_reg[j];
      if (commit_free_valid[j]) begin
        if (w_cnt_run < CW'(NUM_PHYS_REGS)) begin
          w_wr_en[j] = 1'b1;
          w_wr_ptr[j] = f_wrap({1'b0, r_tail} + (PW+1)'(w_push_cnt));
          w_push_cnt  = w_push_cnt + c_OW'(1);
          w_cnt_run   = w_cnt_run + CW'(1);
        end else begin
          w_overflow = 1'b1;
        end
      end
    end

    // Skipped slots inside the consumed span go back to the tail. They were
    // already counted as occupied, so they never overflow.
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_wr_ptr[RET_WIDTH+k]  = '0;
      w_wr_data[RET_WIDTH+k] = free_register_data[k];
      if (w_consume && (c_SW'(k) < w_span) && !frl_ready[k]) begin
        w_wr_en[RET_WIDTH+k]  = 1'b1;
        w_wr_ptr[RET_WIDTH+k] = f_wrap({1'b0, r_tail} + (PW+1)'(w_push_cnt));
        w_push_cnt            = w_push_cnt + c_OW'(1);
      end
    end

    w_tail_next = f_wrap({1'b0, r_tail} + (PW+1)'(w_push_cnt));
    w_head_next = w_consume ? f_wrap({1'b0, r_head} + (PW+1)'(w_span)) : r_head;
  end

  always_ff @(posedge clk or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        r_mem[i] <= (i < c_RESET_CNT) ? PW'(NUM_ARCH_REGS + 1 + i) : '0;
      end
      r_head          <= '0;
      r_tail          <= PW'(c_RESET_CNT);
      r_count         <= CW'(c_RESET_CNT);
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      for (int j = 0; j < c_NPUSH; j++) begin
        if (w_wr_en[j]) r_mem[w_wr_ptr[j]] <= w_wr_data[j];
      end
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_cnt_run;
      if (w_overflow)  r_err_overflow  <= 1'b1;
      if (w_underflow) r_err_underflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_free_reg_list.sv
`default_nettype none
// ============================================================================
//  Module   : tb_free_reg_list
//  Purpose  : Directed self-checking bench for free_reg_list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_free_reg_list;

  localparam int NUM_SLOTS = 6;
  localparam int RET_WIDTH = 2;
  localparam int PW        = 7;
  localparam int CW        = 8;

  logic                          clk = 1'b0;
  logic                          rst_N_in;
  logic [NUM_SLOTS-1:0]          frl_ready;
  logic [NUM_SLOTS-1:0][PW-1:0]  free_register_data;
  logic                          frl_valid;
  logic [RET_WIDTH-1:0]          commit_free_valid;
  logic [RET_WIDTH-1:0][PW-1:0]  commit_free_reg;
  logic [CW-1:0]                 free_count;
  logic                          err_overflow;
  logic                          err_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  free_reg_list dut (
    .clk                (clk),
    .rst_N_in           (rst_N_in),
    .frl_ready          (frl_ready),
    .free_register_data (free_register_data),
    .frl_valid          (frl_valid),
    .commit_free_valid  (commit_free_valid),
    .commit_free_reg    (commit_free_reg),
    .free_count         (free_count),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_slots_seq(input string tag, input int base);
    for (int k = 0; k < NUM_SLOTS; k++) begin
      chk($sformatf("%s_slot%0d", tag, k), 32'(free_register_data[k]), 32'(base + k));
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    frl_ready         = '0;
    commit_free_valid = '0;
    commit_free_reg   = '0;
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic pulse_reset();
    #2 rst_N_in = 1'b0;
    #1 rst_N_in = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_N_in = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);

    // Reset state, observed while reset is held
    chk_slots_seq("rst", 33);
    chk("rst_count", 32'(free_count), 95);
    chk("rst_valid", 32'(frl_valid), 1);
    chk("rst_ovf", 32'(err_overflow), 0);
    chk("rst_unf", 32'(err_underflow), 0);
    rst_N_in = 1'b1;
    step();
    chk("idle_count", 32'(free_count), 95);

    // Full consume
    frl_ready = 6'b111111;
    step();
    idle_inputs();
    chk_slots_seq("full", 39);
    chk("full_count", 32'(free_count), 89);

    // Sparse consume with recycle: span 5, pops 3, slots 2 and 3 recycled
    pulse_reset();
    frl_ready = 6'b010011;
    step();
    idle_inputs();
    chk_slots_seq("sparse", 38);
    chk("sparse_count", 32'(free_count), 92);
    chk("sparse_mem95", 32'(dut.r_mem[95]), 35);
    chk("sparse_mem96", 32'(dut.r_mem[96]), 36);
    chk("sparse_tail", 32'(dut.r_tail), 97);

    // Simultaneous commit + consume
    pulse_reset();
    frl_ready          = 6'b111111;
    commit_free_valid  = 2'b11;
    commit_free_reg[0] = 7'd5;
    commit_free_reg[1] = 7'd7;
    step();
    idle_inputs();
    chk("cc_count", 32'(free_count), 91);
    chk("cc_mem95", 32'(dut.r_mem[95]), 5);
    chk("cc_mem96", 32'(dut.r_mem[96]), 7);
    chk_slots_seq("cc", 39);

    // Drain with commits so the tail wraps: 18 cycles of consume+2 commits
    // (regs 0..35 land at mem[95..127], mem[0..2]), then 3 plain consumes.
    // Head ends at 126, count at 5.
    pulse_reset();
    for (int j = 0; j < 18; j++) begin
      frl_ready          = 6'b111111;
      commit_free_valid  = 2'b11;
      commit_free_reg[0] = PW'(2*j);
      commit_free_reg[1] = PW'(2*j + 1);
      step();
    end
    idle_inputs();
    for (int j = 0; j < 3; j++) begin
      frl_ready = 6'b111111;
      step();
    end
    idle_inputs();
    chk("drain_count", 32'(free_count), 5);
    chk("drain_valid", 32'(frl_valid), 0);
    chk("drain_unf0", 32'(err_underflow), 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_slot%0d", k), 32'(free_register_data[k]), 32'(31 + k));
    end

    // Underflow alone: nothing popped
    frl_ready = 6'b000001;
    step();
    idle_inputs();
    chk("unf_flag", 32'(err_underflow), 1);
    chk("unf_count", 32'(free_count), 5);
    chk("unf_slot0", 32'(free_register_data[0]), 31);

    // Underflow with a commit of reg 9 in the same cycle
    frl_ready          = 6'b000001;
    commit_free_valid  = 2'b01;
    commit_free_reg[0] = 7'd9;
    step();
    idle_inputs();
    chk("unfc_count", 32'(free_count), 6);
    chk("unfc_valid", 32'(frl_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap_slot%0d", k), 32'(free_register_data[k]), 32'(31 + k));
    end
    chk("wrap_slot5", 32'(free_register_data[5]), 9);

    // Consume those six; head wraps 126 -> 4
    frl_ready = 6'b111111;
    step();
    idle_inputs();
    chk("wrap_count", 32'(free_count), 0);
    chk("wrap_head", 32'(dut.r_head), 4);
    chk("unf_sticky", 32'(err_underflow), 1);

    // Asynchronous reset mid-operation, checked before any clock edge
    #2 rst_N_in = 1'b0;
    #1;
    chk_slots_seq("arst", 33);
    chk("arst_count", 32'(free_count), 95);
    chk("arst_valid", 32'(frl_valid), 1);
    chk("arst_unf", 32'(err_underflow), 0);
    chk("arst_ovf", 32'(err_overflow), 0);
    rst_N_in = 1'b1;
    @(negedge clk);

    // Overflow: fill from 95 to 127, then one lane fits and one is dropped
    for (int j = 0; j < 16; j++) begin
      commit_free_valid  = 2'b11;
      commit_free_reg[0] = 7'd50;
      commit_free_reg[1] = 7'd60;
      step();
    end
    chk("fill_count", 32'(free_count), 127);
    chk("fill_ovf", 32'(err_overflow), 0);
    commit_free_valid  = 2'b11;
    commit_free_reg[0] = 7'd70;
    commit_free_reg[1] = 7'd80;
    step();
    idle_inputs();
    chk("ovf_count", 32'(free_count), 128);
    chk("ovf_flag", 32'(err_overflow), 1);
    chk("ovf_mem127", 32'(dut.r_mem[127]), 70);
    chk("ovf_mem0", 32'(dut.r_mem[0]), 33);
    chk("ovf_tail", 32'(dut.r_tail), 0);
    chk("ovf_unf", 32'(err_underflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
